data_mem_responder: RTL and testbench

Responder end of the execute-stage memory request interface. Accepts the read/write enables, ALU-computed address and store data issued by the pipeline, and services them from an internal word-addressed data array after a fixed, configurable number of wait states. While an access is in progress it drives `ready` low so the pipeline can freeze. It returns load data registered with a one-cycle completion strobe.

---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 100 ++++++++++
 tb/tb_data_mem_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Execute-stage memory request bus: the pipeline is the master and the
// data memory responder is the slave.
interface data_mem_responder_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;
    logic        addr_err;

    modport master (
        output mem_r_en, mem_w_en, address, write_data,
        input  ready, read_data, addr_err
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, write_data,
        output ready, read_data, addr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data array behind a fixed-latency request bus; holds ready
// low for the whole access and presents the result for one DONE cycle.
module data_mem_responder #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   lat_idx;
    logic [31:0]     lat_data;
    logic            lat_wr;
    logic            lat_ok;
    logic [31:0]     read_data;
    logic            addr_err;
    logic            ready;
    logic [31:0]     mem [DEPTH];

    logic            req;
    logic [31:0]     off;
    logic            in_range;
    logic            finish;

    assign req      = bus.mem_r_en | bus.mem_w_en;
    assign off      = bus.address - BASE_ADDR;
    // off < 4*DEPTH is the same test as off[31:2] < DEPTH
    assign in_range = (bus.address >= BASE_ADDR) && (off < (32'(DEPTH) << 2));
    assign finish   = (state == BUSY) && (cnt == '0);

    assign bus.ready     = ready;
    assign bus.read_data = read_data;
    assign bus.addr_err  = addr_err;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_nx = BUSY;
            end
            BUSY: if (cnt == '0) state_nx = DONE;
            DONE: begin
                ready    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            read_data <= '0;
            addr_err  <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= '0;
            lat_wr    <= 1'b0;
            lat_ok    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    cnt      <= CW'(WAIT_CYCLES - 1);
                    lat_idx  <= off[IW+1:2];
                    lat_data <= bus.write_data;
                    lat_wr   <= bus.mem_w_en;
                    lat_ok   <= in_range;
                end
                BUSY: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        addr_err <= ~lat_ok;
                        if (!lat_wr) read_data <= lat_ok ? mem[lat_idx] : 32'd0;
                    end
                end
                DONE:    addr_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Contents survive reset; a write aborted by reset never reaches here.
    always_ff @(posedge clk) begin
        if (!rst && finish && lat_wr && lat_ok) mem[lat_idx] <= lat_data;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a transaction
// level model of the array and the access timeline.
module tb_data_mem_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          W     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int ntest = 0;
    int nfail = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model [DEPTH];
    logic        exp_ready;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          chk_en = 1'b0;

    int          done_cyc;
    logic [31:0] last_rd;
    logic        last_err;
    logic        last_ready;
    int          last_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",     {31'b0, bus.ready},    {31'b0, exp_ready});
            chk("read_data", bus.read_data,         exp_rd);
            chk("addr_err",  {31'b0, bus.addr_err}, {31'b0, exp_err});
        end
    end

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    // Entered and left in an IDLE cycle, #1 after the rising edge.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        bit ok;
        int idx;
        ok  = in_rng(a);
        idx = ok ? int'((a - BASE) >> 2) : 0;
        bus.mem_w_en   = wr;
        bus.mem_r_en   = rd;
        bus.address    = a;
        bus.write_data = d;
        exp_ready      = 1'b0;
        #1;
        last_low = (bus.ready == 1'b0) ? 1 : 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            if (k <= W) begin
                if (bus.ready == 1'b0) last_low++;
                if (!hold) begin
                    bus.mem_r_en   = 1'($urandom);
                    bus.mem_w_en   = 1'($urandom);
                    bus.address    = $urandom;
                    bus.write_data = $urandom;
                end
            end else if (!hold) begin
                bus.mem_r_en = 1'b0;
                bus.mem_w_en = 1'b0;
            end
        end
        done_cyc  = cyc;
        exp_ready = 1'b1;
        exp_err   = ~ok;
        if (wr) begin
            if (ok) model[idx] = d;
        end else begin
            exp_rd = ok ? model[idx] : 32'd0;
        end
        last_rd    = bus.read_data;
        last_err   = bus.addr_err;
        last_ready = bus.ready;
        @(posedge clk); #1;
        exp_err   = 1'b0;
        exp_ready = ~(bus.mem_r_en | bus.mem_w_en);
    endtask

    task automatic idle(input int n);
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        exp_ready    = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1;
        logic [31:0] a;
        rst            = 1'b1;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        @(posedge clk); #1;
        exp_ready = 1'b1;
        exp_rd    = 32'd0;
        exp_err   = 1'b0;
        chk_en    = 1'b1;
        chk("reset_ready", {31'b0, bus.ready},    32'd1);
        chk("reset_rd",    bus.read_data,         32'd0);
        chk("reset_err",   {31'b0, bus.addr_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 1'($urandom));
        idle(2);

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        chk("wr_low_cycles", 32'(last_low),           32'd5);
        chk("wr_done_ready", {31'b0, last_ready},     32'd1);
        chk("wr_done_err",   {31'b0, last_err},       32'd0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        chk("rd_1028",       last_rd,                 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1031, 32'h0, 1'b0);
        chk("rd_1031",       last_rd,                 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
        chk("rd_1020_data",  last_rd,                 32'd0);
        chk("rd_1020_err",   {31'b0, last_err},       32'd1);
        access(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'hCAFEF00D, 1'b0);
        chk("wr_oob_err",    {31'b0, last_err},       32'd1);
        access(1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 1'b0);
        idle(1);

        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0);
        chk("both_rd_kept",  last_rd,                 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        chk("rd_1032",       last_rd,                 32'h12345678);

        access(1'b1, 1'b0, 32'd1036, 32'h1, 1'b0);
        bus.mem_w_en   = 1'b1;
        bus.mem_r_en   = 1'b0;
        bus.address    = 32'd1036;
        bus.write_data = 32'h2;
        exp_ready      = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.mem_w_en = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        exp_ready = 1'b1;
        exp_rd    = 32'd0;
        exp_err   = 1'b0;
        chk("rst_busy_ready", {31'b0, bus.ready}, 32'd1);
        chk("rst_busy_rd",    bus.read_data,      32'd0);
        access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
        chk("rd_1036",        last_rd,            32'h1);

        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
        d1 = done_cyc;
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);
        chk("b2b_space1", 32'(done_cyc - d1), 32'(W + 2));
        d1 = done_cyc;
        access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b1);
        chk("b2b_space2", 32'(done_cyc - d1), 32'(W + 2));
        chk("b2b_last",   last_rd,            32'h1);
        idle(10);

        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) != 0) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else case ($urandom_range(0, 5))
                0: a = BASE - 32'd4;
                1: a = BASE - 32'd1;
                2: a = BASE + 32'(4 * DEPTH);
                3: a = BASE + 32'(4 * DEPTH + 3);
                4: a = 32'hFFFF_FFFC;
                default: a = 32'd0;
            endcase
            access(op != 0, op != 1, a, $urandom, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
